spi_slave_regfile: RTL and testbench

// SPI responder (device side) for the APB SPI master's command/address/data framing.

---
 rtl/spi_slave_regfile.sv | 198 +++++++++++++++++++
 tb/tb_spi_slave_regfile.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_regfile.sv
// spi_slave_regfile: SPI mode-0 responder backed by a REG_NUM x DATA_W register file.
// A frame is cmd[3:0], addr[3:0], then DATA_W data bits, all MSB first. sck, nss and
// mosi are oversampled in the PCLK domain and every protocol decision is taken on
// edges of the synchronized copies, so sck high/low times must span several PCLKs.
module spi_slave_regfile #(
    parameter int DATA_W      = 16,
    parameter int REG_NUM     = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic              PCLK,
    input  logic              PRSTN,
    input  logic              sck,
    input  logic              nss,
    input  logic              mosi,
    output logic              miso,
    output logic              miso_oe,
    output logic              wr_valid,
    output logic [3:0]        wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              frame_err,
    input  logic [3:0]        dbg_addr,
    output logic [DATA_W-1:0] dbg_rdata
);

    localparam logic [3:0] CMD_WR = 4'b1011;
    localparam logic [3:0] CMD_RD = 4'b1010;
    // Wide enough for both the 4-bit header phases and the data phase.
    localparam int         CNT_W  = (DATA_W > 4) ? $clog2(DATA_W) : 2;

    typedef enum logic [2:0] {
        S_IDLE, S_CMD, S_ADDR, S_WR, S_RD, S_IGN, S_DONE
    } state_t;

    logic [SYNC_STAGES-1:0] r_sck_sync, r_nss_sync, r_mosi_sync;
    logic                   r_sck_d, r_nss_d;
    logic [SYNC_STAGES:0]   r_sync_vld;

    state_t                 r_state;
    logic [CNT_W-1:0]       r_bit_cnt;
    logic [3:0]             r_cmd, r_addr;
    logic [DATA_W-1:0]      r_shreg;
    logic [DATA_W-1:0]      r_regs [REG_NUM];

    logic                   w_sck_s, w_nss_s, w_mosi, w_sync_ok;
    logic                   w_sck_rise, w_sck_fall, w_nss_rise, w_nss_fall;
    logic                   w_last_hdr, w_last_data;
    logic [3:0]             w_addr_next;
    logic [DATA_W-1:0]      w_shift_in, w_rd_snap;

    // Synchronize the SPI pins and keep a one-cycle-delayed copy for edge detection.
    always_ff @(posedge PCLK or negedge PRSTN) begin
        if (!PRSTN) begin
            r_sck_sync  <= '0;
            r_nss_sync  <= '1;
            r_mosi_sync <= '0;
            r_sck_d     <= 1'b0;
            r_nss_d     <= 1'b1;
            r_sync_vld  <= '0;
        end else begin
            r_sck_sync  <= {r_sck_sync[SYNC_STAGES-2:0], sck};
            r_nss_sync  <= {r_nss_sync[SYNC_STAGES-2:0], nss};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi};
            r_sck_d     <= r_sck_sync[SYNC_STAGES-1];
            r_nss_d     <= r_nss_sync[SYNC_STAGES-1];
            r_sync_vld  <= {r_sync_vld[SYNC_STAGES-1:0], 1'b1};
        end
    end

    assign w_sck_s = r_sck_sync[SYNC_STAGES-1];
    assign w_nss_s = r_nss_sync[SYNC_STAGES-1];
    assign w_mosi  = r_mosi_sync[SYNC_STAGES-1];

    // Edges only count once both the synced value and its delayed copy hold real pin
    // samples. Without this, nss held low across reset would look like a fresh nss
    // fall and the slave would join a frame already in progress.
    assign w_sync_ok  = r_sync_vld[SYNC_STAGES];
    assign w_sck_rise = w_sync_ok &  w_sck_s & ~r_sck_d;
    assign w_sck_fall = w_sync_ok & ~w_sck_s &  r_sck_d;
    assign w_nss_rise = w_sync_ok &  w_nss_s & ~r_nss_d;
    assign w_nss_fall = w_sync_ok & ~w_nss_s &  r_nss_d;

    assign w_last_hdr  = (r_bit_cnt == CNT_W'(3));
    assign w_last_data = (r_bit_cnt == CNT_W'(DATA_W-1));
    assign w_addr_next = {r_addr[2:0], w_mosi};
    assign w_shift_in  = {r_shreg[DATA_W-2:0], w_mosi};
    assign w_rd_snap   = (int'(w_addr_next) < REG_NUM) ? r_regs[w_addr_next] : '0;
    assign dbg_rdata   = (int'(dbg_addr) < REG_NUM) ? r_regs[dbg_addr] : '0;

    // Frame decoder: header shifting, data phase, register commit and miso drive.
    always_ff @(posedge PCLK or negedge PRSTN) begin
        if (!PRSTN) begin
            r_state   <= S_IDLE;
            r_bit_cnt <= '0;
            r_cmd     <= '0;
            r_addr    <= '0;
            r_shreg   <= '0;
            miso      <= 1'b0;
            miso_oe   <= 1'b0;
            wr_valid  <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            frame_err <= 1'b0;
            // NOTE: the register file has a defined reset value, so it is cleared with
            // the rest of the state instead of being left as an unreset memory.
            for (int i = 0; i < REG_NUM; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            wr_valid  <= 1'b0;
            frame_err <= 1'b0;
            if (w_nss_rise && r_state != S_IDLE) begin
                // Only an unfinished frame is an error; IGN and DONE end cleanly.
                frame_err <= (r_state inside {S_CMD, S_ADDR, S_WR, S_RD});
                r_state   <= S_IDLE;
                miso_oe   <= 1'b0;
                miso      <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        // An sck rise in the same cycle as the nss fall is not counted.
                        if (w_nss_fall) begin
                            r_state   <= S_CMD;
                            r_bit_cnt <= '0;
                        end
                    end
                    S_CMD: begin
                        if (w_sck_rise) begin
                            r_cmd <= {r_cmd[2:0], w_mosi};
                            if (w_last_hdr) begin
                                r_state   <= S_ADDR;
                                r_bit_cnt <= '0;
                            end else begin
                                r_bit_cnt <= r_bit_cnt + 1'b1;
                            end
                        end
                    end
                    S_ADDR: begin
                        if (w_sck_rise) begin
                            r_addr <= w_addr_next;
                            if (w_last_hdr) begin
                                r_bit_cnt <= '0;
                                if (r_cmd == CMD_WR) begin
                                    r_state <= S_WR;
                                end else if (r_cmd == CMD_RD) begin
                                    // Snapshot now so the frame in flight is immune to later writes.
                                    r_state <= S_RD;
                                    r_shreg <= w_rd_snap;
                                    miso_oe <= 1'b1;
                                end else begin
                                    r_state <= S_IGN;
                                end
                            end else begin
                                r_bit_cnt <= r_bit_cnt + 1'b1;
                            end
                        end
                    end
                    S_WR: begin
                        if (w_sck_rise) begin
                            r_shreg <= w_shift_in;
                            if (w_last_data) begin
                                if (int'(r_addr) < REG_NUM) begin
                                    r_regs[r_addr] <= w_shift_in;
                                end
                                wr_valid <= 1'b1;
                                wr_addr  <= r_addr;
                                wr_data  <= w_shift_in;
                                r_state  <= S_DONE;
                            end else begin
                                r_bit_cnt <= r_bit_cnt + 1'b1;
                            end
                        end
                    end
                    S_RD: begin
                        if (w_sck_fall) begin
                            miso    <= r_shreg[DATA_W-1];
                            r_shreg <= r_shreg << 1;
                        end else if (w_sck_rise) begin
                            if (w_last_data) begin
                                r_state <= S_DONE;
                                miso_oe <= 1'b0;
                                miso    <= 1'b0;
                            end else begin
                                r_bit_cnt <= r_bit_cnt + 1'b1;
                            end
                        end
                    end
                    S_IGN, S_DONE: begin
                        miso_oe <= 1'b0;
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_slave_regfile.sv
// tb_spi_slave_regfile: drives whole SPI mode-0 frames as a master would and checks
// the slave against a register-array model of what each frame must do.
module tb_spi_slave_regfile;

    localparam int DATA_W = 16;
    localparam int HALF   = 5;   // sck half period in PCLK cycles
    localparam int SETTLE = 8;   // nss-high time that lets every pulse drain

    logic        PCLK  = 1'b0;
    logic        PRSTN = 1'b1;
    logic        sck   = 1'b0;
    logic        nss   = 1'b1;
    logic        mosi  = 1'b0;
    logic        miso, miso_oe, wr_valid, frame_err;
    logic [3:0]  wr_addr;
    logic [15:0] wr_data, dbg_rdata;
    logic [3:0]  dbg_addr = 4'd0;

    int          checks   = 0;
    int          failures = 0;
    logic [15:0] model_regs [16];
    bit          idle_chk = 1'b0;
    int          wr_cnt   = 0;
    int          err_cnt  = 0;
    logic [3:0]  last_wr_addr = 4'd0;
    logic [15:0] last_wr_data = 16'd0;

    spi_slave_regfile #(.DATA_W(16), .REG_NUM(16), .SYNC_STAGES(2)) dut (
        .PCLK      (PCLK),
        .PRSTN     (PRSTN),
        .sck       (sck),
        .nss       (nss),
        .mosi      (mosi),
        .miso      (miso),
        .miso_oe   (miso_oe),
        .wr_valid  (wr_valid),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .frame_err (frame_err),
        .dbg_addr  (dbg_addr),
        .dbg_rdata (dbg_rdata)
    );

    always #5 PCLK = ~PCLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge PCLK);
        #1;
    endtask

    // One master bit: present mosi, raise sck and capture miso/miso_oe there, drop sck.
    task automatic sck_bit(input logic b, output logic m, output logic o);
        mosi = b;
        wait_clk(HALF);
        sck = 1'b1;
        m = miso;
        o = miso_oe;
        wait_clk(HALF);
        sck = 1'b0;
    endtask

    // The compare process sweeps dbg_addr; wait until it points at a and sample.
    task automatic peek_reg(input logic [3:0] a, output logic [15:0] v);
        v = 'x;
        for (int i = 0; i < 40; i++) begin
            @(posedge PCLK);
            #1;
            if (dbg_addr == a) begin
                v = dbg_rdata;
                break;
            end
        end
    endtask

    // Send cmd/addr and ndata data bits, then hold nss high for gap cycles.
    task automatic run_frame(input logic [3:0] cmd, input logic [3:0] addr,
                             input logic [15:0] data, input int ndata, input int gap,
                             output logic [15:0] rd);
        logic [23:0] bits;
        logic [15:0] exp_rd;
        logic        m, o;
        int          wr0, err0, oe_hi, exp_wr, exp_err, exp_oe;
        bit          is_wr, is_rd, full;
        bits    = {cmd, addr, data};
        wr0     = wr_cnt;
        err0    = err_cnt;
        oe_hi   = 0;
        rd      = '0;
        is_wr   = (cmd == 4'b1011);
        is_rd   = (cmd == 4'b1010);
        full    = (ndata == DATA_W);
        exp_wr  = (is_wr && full) ? 1 : 0;
        exp_err = ((is_wr || is_rd) && !full) ? 1 : 0;
        exp_oe  = is_rd ? ndata : 0;
        exp_rd  = model_regs[addr];
        idle_chk = 1'b0;
        nss = 1'b0;
        wait_clk(HALF);
        for (int i = 0; i < 8 + ndata; i++) begin
            sck_bit(bits[23-i], m, o);
            if (o) oe_hi++;
            if (i >= 8) rd = {rd[14:0], m};
        end
        wait_clk(HALF);
        check("wr_valid pulses", wr_cnt - wr0, exp_wr);
        if (exp_wr == 1) begin
            check("wr_addr", {28'd0, last_wr_addr}, {28'd0, addr});
            check("wr_data", {16'd0, last_wr_data}, {16'd0, data});
            model_regs[addr] = data;
        end
        check("miso_oe bit count", oe_hi, exp_oe);
        if (is_rd && full) check("read data", {16'd0, rd}, {16'd0, exp_rd});
        nss = 1'b1;
        wait_clk(gap);
        if (gap >= SETTLE) begin
            check("frame_err pulses", err_cnt - err0, exp_err);
            idle_chk = 1'b1;
        end
    endtask

    // Pulse counting plus the per-cycle comparison against the model while quiet.
    initial begin
        forever begin
            @(negedge PCLK);
            if (wr_valid) begin
                wr_cnt++;
                last_wr_addr = wr_addr;
                last_wr_data = wr_data;
            end
            if (frame_err) err_cnt++;
            if (idle_chk) begin
                check("quiet outputs", {28'd0, miso, miso_oe, wr_valid, frame_err}, 32'd0);
                check("dbg_rdata", {16'd0, dbg_rdata}, {16'd0, model_regs[dbg_addr]});
            end
            dbg_addr = dbg_addr + 4'd1;
        end
    end

    initial begin
        logic [15:0] rd, v;
        logic [23:0] bits6;
        logic        m, o;
        int          wr0, err0;
        for (int i = 0; i < 16; i++) model_regs[i] = 16'd0;

        #2 PRSTN = 1'b0;
        wait_clk(3);
        check("reset outputs", {8'd0, miso, miso_oe, wr_valid, frame_err, wr_addr, wr_data}, 32'd0);
        idle_chk = 1'b1;
        wait_clk(20);
        peek_reg(4'd4, v);
        check("reset reg4", {16'd0, v}, 32'h0000);
        PRSTN = 1'b1;
        wait_clk(SETTLE);

        // Basic write, then read back.
        run_frame(4'b1011, 4'd3, 16'h1111, 16, SETTLE, rd);
        peek_reg(4'd3, v);
        check("T1 dbg reg3", {16'd0, v}, 32'h1111);
        check("T1 wr_data literal", {16'd0, last_wr_data}, 32'h1111);
        run_frame(4'b1010, 4'd3, 16'h0000, 16, SETTLE, rd);
        check("T2 read literal", {16'd0, rd}, 32'h1111);
        peek_reg(4'd3, v);
        check("T2 reg3 kept", {16'd0, v}, 32'h1111);

        // Unknown command is ignored, including when cut short.
        run_frame(4'hF, 4'd5, 16'hFFFF, 16, SETTLE, rd);
        peek_reg(4'd5, v);
        check("T3 reg5", {16'd0, v}, 32'h0000);
        run_frame(4'h3, 4'd6, 16'h1234, 4, SETTLE, rd);

        // Aborted write leaves the register alone; aborted read flags an error.
        run_frame(4'b1011, 4'd7, 16'h7777, 16, SETTLE, rd);
        run_frame(4'b1011, 4'd7, 16'h0F0F, 10, SETTLE, rd);
        peek_reg(4'd7, v);
        check("T4 reg7 kept", {16'd0, v}, 32'h7777);
        run_frame(4'b1010, 4'd7, 16'h0000, 5, SETTLE, rd);

        // MSB/LSB ordering, and mosi activity during a read is ignored.
        run_frame(4'b1011, 4'd0, 16'h8001, 16, SETTLE, rd);
        run_frame(4'b1010, 4'd0, 16'hFFFF, 16, SETTLE, rd);
        check("read 8001 literal", {16'd0, rd}, 32'h8001);
        run_frame(4'b1010, 4'd7, 16'h0000, 16, SETTLE, rd);
        check("read 7777 literal", {16'd0, rd}, 32'h7777);

        // Back-to-back writes with a 2-cycle nss-high gap.
        wr0  = wr_cnt;
        err0 = err_cnt;
        for (int k = 0; k < 6; k++) begin
            run_frame(4'b1011, 4'd3, 16'(16'h1111 * k), 16, (k == 5) ? SETTLE : 2, rd);
        end
        check("T5 wr pulses", wr_cnt - wr0, 6);
        check("T5 frame_err", err_cnt - err0, 0);
        run_frame(4'b1010, 4'd3, 16'h0000, 16, SETTLE, rd);
        check("T5 read literal", {16'd0, rd}, 32'h5555);

        // Reset in the middle of a write; the rest of that frame must be dropped.
        idle_chk = 1'b0;
        wr0   = wr_cnt;
        err0  = err_cnt;
        bits6 = {4'b1011, 4'd2, 16'hABCD};
        nss = 1'b0;
        wait_clk(HALF);
        for (int i = 0; i < 6; i++) sck_bit(bits6[23-i], m, o);
        wait_clk(2);
        PRSTN = 1'b0;
        wait_clk(2);
        check("T6 reset outputs", {8'd0, miso, miso_oe, wr_valid, frame_err, wr_addr, wr_data}, 32'd0);
        for (int i = 0; i < 16; i++) model_regs[i] = 16'd0;
        idle_chk = 1'b1;
        wait_clk(20);
        peek_reg(4'd3, v);
        check("T6 reg3 cleared", {16'd0, v}, 32'h0000);
        PRSTN = 1'b1;
        wait_clk(2);
        for (int i = 6; i < 24; i++) sck_bit(bits6[23-i], m, o);
        wait_clk(HALF);
        nss = 1'b1;
        wait_clk(SETTLE);
        check("T6 dropped frame wr", wr_cnt - wr0, 0);
        check("T6 dropped frame err", err_cnt - err0, 0);
        run_frame(4'b1011, 4'd2, 16'hABCD, 16, SETTLE, rd);
        peek_reg(4'd2, v);
        check("T6 reg2", {16'd0, v}, 32'hABCD);
        run_frame(4'b1010, 4'd2, 16'h0000, 16, SETTLE, rd);
        check("T6 read literal", {16'd0, rd}, 32'hABCD);

        wait_clk(5);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
